// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle for the bit-serial adder controller.
// The requester drives the master side; the controller is the slave.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
    input  start_valid, a, b, cin,
    input  result_ready,
    output start_ready, result_valid,
    output sum, cout, busy
  );

  modport master (
    output start_valid, a, b, cin,
    output result_ready,
    input  start_ready, result_valid,
    input  sum, cout, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder slice
// stepped LSB first over WIDTH cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_x, fa_y, fa_s, fa_co;

  // The single adder slice shared by every bit position
  assign fa_x  = a_sh_q[0];
  assign fa_y  = b_sh_q[0];
  assign fa_s  = fa_x ^ fa_y ^ c_q;
  assign fa_co = (fa_x & fa_y) | (c_q & (fa_x ^ fa_y));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Out-of-range count means corrupted state: bail out
        if (cnt_q >= CW'(WIDTH)) begin
          state_d = IDLE;
        end else begin
          s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
          a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
          c_d    = fa_co;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
            cout_d  = fa_co;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.busy         = (state_q == RUN) || (state_q == DONE);
  assign bus.sum          = sum_q;
  assign bus.cout         = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks for serial_adder_ctrl.
// Inputs change and outputs are sampled 1ns after rising edges.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) sif ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // One transaction; hold > 0 stalls result_ready,
  // iso drives junk with start_valid high during RUN.
  task automatic do_add(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin,
                        input int hold,
                        input bit iso,
                        output logic [W-1:0] s,
                        output logic co,
                        output int lat);
    logic [W-1:0] s0;
    logic         c0;
    int           unstable;
    lat = -1;
    s = '0;
    co = 1'b0;
    sif.a = a;
    sif.b = b;
    sif.cin = cin;
    sif.start_valid = 1'b1;
    sif.result_ready = 1'b0;
    @(posedge clk);
    #1;
    if (iso) begin
      sif.a = '1;
      sif.b = '1;
      sif.cin = 1'b1;
    end else begin
      sif.start_valid = 1'b0;
    end
    for (int k = 1; k <= 4 * W; k++) begin
      @(posedge clk);
      #1;
      if (sif.result_valid) begin
        lat = k;
        break;
      end
    end
    sif.start_valid = 1'b0;
    if (lat < 0) begin
      check("latency_timeout", 32'd0, 32'd1);
      return;
    end
    s = sif.sum;
    co = sif.cout;
    if (hold > 0) begin
      s0 = sif.sum;
      c0 = sif.cout;
      unstable = 0;
      for (int k = 0; k < hold; k++) begin
        @(posedge clk);
        #1;
        if (!sif.result_valid || sif.sum !== s0 ||
            sif.cout !== c0)
          unstable++;
      end
      check("bp_stable", unstable, 0);
    end
    sif.result_ready = 1'b1;
    @(posedge clk);
    #1;
    sif.result_ready = 1'b0;
    check("retire_valid", sif.result_valid, 1'b0);
    check("retire_ready", sif.start_ready, 1'b1);
  endtask

  initial begin
    logic [W-1:0] s;
    logic         co;
    int           lat;
    int           extra;
    logic [W:0]   ref_v;
    logic [W-1:0] ra, rb;
    logic         rc;

    vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    sif.start_valid = 1'b0;
    sif.a = '0;
    sif.b = '0;
    sif.cin = 1'b0;
    sif.result_ready = 1'b0;

    #12;
    check("rst_valid", sif.result_valid, 1'b0);
    check("rst_sum", sif.sum, 8'h00);
    check("rst_cout", sif.cout, 1'b0);
    check("rst_busy", sif.busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready", sif.start_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0,
             s, co, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
      check($sformatf("vec%0d_lat", i), lat, W);
    end

    // Backpressure: five stalled cycles in DONE
    do_add(8'h3C, 8'h5A, 1'b0, 5, 1'b0, s, co, lat);
    check("bp_sum", s, 8'h96);
    check("bp_cout", co, 1'b0);
    check("bp_lat", lat, W);

    // Operand isolation during RUN
    do_add(8'h12, 8'h34, 1'b0, 0, 1'b1, s, co, lat);
    check("iso_sum", s, 8'h46);
    check("iso_cout", co, 1'b0);
    extra = 0;
    for (int k = 0; k < 3 * W; k++) begin
      @(posedge clk);
      #1;
      if (sif.result_valid || sif.busy) extra++;
    end
    check("iso_single", extra, 0);

    // Asynchronous reset in the middle of RUN
    sif.a = 8'h55;
    sif.b = 8'h0F;
    sif.cin = 1'b0;
    sif.start_valid = 1'b1;
    @(posedge clk);
    #1;
    sif.start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", sif.result_valid, 1'b0);
    check("mid_rst_busy", sif.busy, 1'b0);
    check("mid_rst_sum", sif.sum, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", sif.start_ready, 1'b1);
    do_add(8'h01, 8'h01, 1'b0, 0, 1'b0, s, co, lat);
    check("post_rst_sum", s, 8'h02);
    check("post_rst_cout", co, 1'b0);

    // Random sweep against an integer reference
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      do_add(ra, rb, rc, 0, 1'b0, s, co, lat);
      check($sformatf("rnd%0d_sum", i), s, ref_v[W-1:0]);
      check($sformatf("rnd%0d_cout", i), co, ref_v[W]);
      check($sformatf("rnd%0d_lat", i), lat, W);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial N-bit adder controller. It sequences a single internal 1-bit full-adder cell over WIDTH cycles, LSB first, so that one adder slice performs a WIDTH-bit addition. Operands enter through a valid/ready request handshake. The result leaves through a valid/ready response handshake. It sits between a requester (a test harness or a small datapath) and the 1-bit adder resource.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  reset; asynchronous assert, active-low.
start_valid  input  1  requester has operands on a/b/cin.
start_ready  output  1  controller can accept operands (high only in IDLE).
a  input  WIDTH  operand A; sampled only on the accept edge.
b  input  WIDTH  operand B; sampled only on the accept edge.
cin  input  1  initial carry-in; sampled only on the accept edge.
result_valid  output  1  sum/cout are valid (high only in DONE).
result_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered sum, a + b + cin modulo 2^WIDTH.
cout  output  1  registered final carry-out.
busy  output  1  high in RUN or DONE.

Behaviour:
- Internal full-adder cell, combinational, one instance only. Per bit: s = x ^ y ^ c; co = (x & y) | (c & (x ^ y)).
- State registers: operand shift registers A_sh and B_sh (WIDTH each), carry register C, sum shift register S_sh (WIDTH), bit counter cnt (clog2(WIDTH)+1 bits), FSM state.
- Reset (rst_n low, asynchronous):
  - state = IDLE; all registers = 0.
  - Outputs: start_ready=1 once reset is released, result_valid=0, sum=0, cout=0, busy=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On a clock edge with start_valid=1: A_sh<=a, B_sh<=b, C<=cin, cnt<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN:
  - start_ready=0.
  - Each edge: feed A_sh[0], B_sh[0], C to the cell.
  - Shift S_sh right with s entering at the MSB; shift A_sh and B_sh right by one.
  - C<=co; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: state<=DONE, sum<=final S_sh (all WIDTH bits), cout<=co.
  - RUN lasts exactly WIDTH cycles.
  - start_valid and operand changes during RUN are ignored.
- DONE:
  - result_valid=1; sum and cout are held stable.
  - On an edge with result_ready=1: state<=IDLE; result_valid drops next cycle.
  - No new request is accepted in the same cycle as result retirement.
  - Back-to-back throughput is therefore one addition per WIDTH+2 cycles minimum.
- Latency: accept edge at T means result_valid is high after edge T+WIDTH.
- Backpressure: result_ready low holds DONE indefinitely with sum/cout unchanged.
- sum/cout keep their last value in IDLE; they are overwritten only on RUN completion.
- Reset mid-operation: the asynchronous clear applies immediately. The partial result is discarded and never presented. The FSM restarts in IDLE.
- Arithmetic: unsigned. Overflow is reported only via cout; sum wraps modulo 2^WIDTH.
- cnt must not wrap within RUN. A cnt value ≥ WIDTH is unreachable; if it occurs, force the FSM to IDLE.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, result_ready=1:
  - start_ready=0 for 8 cycles.
  - result_valid high after edge T+8.
  - sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure:
  - Hold result_ready=0 for 5 cycles after result_valid rises; result_valid, sum and cout stay stable.
  - Assert result_ready -> IDLE next cycle, start_ready=1.
- Input isolation:
  - Accept a=0x12, b=0x34, cin=0, then drive a=b=0xFF and start_valid=1 throughout RUN.
  - Result is sum=0x46, cout=0; exactly one result is produced.
- Reset mid-op:
  - Pull rst_n low at cycle 4 of RUN -> result_valid=0, busy=0, sum=0 immediately.
  - After release, a fresh request 0x01+0x01 -> 0x02.
- Randomized sweep: 1000 random a/b/cin values checked against a reference a+b+cin model. Every latency is exactly WIDTH cycles from accept to result_valid.
